// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, mem_port_arbiter and the unified Memory.
// The arbiter connects through the slave modport; the requester/Memory side uses master.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    output i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_din, mem_read, mem_write, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_din, mem_read, mem_write, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified Memory between the fetch (I) and data (D) requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise D has fixed priority over I.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

  if ((MEM_LATENCY < 1) || (MEM_LATENCY > 15)) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY=%0d is outside 1..15", MEM_LATENCY);
  end

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_is_d_q, gnt_is_d_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        any_req;
  logic        pick_d;

  assign any_req = bus.i_req || bus.d_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers who was granted last; resets to D so the first tie goes to I.
  logic last_gnt_d_q, last_gnt_d_d;

  always_comb begin
    pick_d = bus.d_req;
    if (bus.i_req && bus.d_req) begin
      pick_d = !last_gnt_d_q;
    end
  end

  always_comb begin
    last_gnt_d_d = last_gnt_d_q;
    if ((state_q == IDLE) && any_req) begin
      last_gnt_d_d = pick_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt_d_q <= 1'b1;
    end else begin
      last_gnt_d_q <= last_gnt_d_d;
    end
  end
`else
  always_comb begin
    pick_d = bus.d_req;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      gnt_is_d_q <= 1'b0;
      addr_q     <= 32'h0;
      we_q       <= 1'b0;
      wdata_q    <= 32'h0;
      i_rdata_q  <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_is_d_q <= gnt_is_d_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // The whole request is captured at grant, so a requester dropping req mid-access is harmless.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_is_d_d = gnt_is_d_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_is_d_d = pick_d;
          addr_d     = pick_d ? bus.d_addr : bus.i_addr;
          we_d       = pick_d && bus.d_we;
          wdata_d    = pick_d ? bus.d_wdata : 32'h0;
          cnt_d      = 4'd0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          if (!we_q) begin
            if (gnt_is_d_q) begin
              d_rdata_d = bus.mem_dout;
            end else begin
              i_rdata_d = bus.mem_dout;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes decode straight from state so an async reset drops them without waiting for a clock.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_din   = wdata_q;
  assign bus.mem_read  = (state_q == BUSY) && !we_q;
  assign bus.mem_write = (state_q == BUSY) && we_q && (cnt_q == CNT_LAST);
  assign bus.i_ack     = (state_q == DONE) && !gnt_is_d_q;
  assign bus.d_ack     = (state_q == DONE) && gnt_is_d_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state_q != IDLE);

  a_no_read_and_write: assert property (@(posedge clk) disable iff (!reset)
    !(bus.mem_read && bus.mem_write));

  a_write_only_in_busy: assert property (@(posedge clk) disable iff (!reset)
    bus.mem_write |-> (state_q == BUSY));

endmodule
